// File: rtl/switch_pkg.sv
// Shared types for the switch multiplier: operand/product types, register pair,
// multiply FSM states and the operand magnitude helper.
package switch_pkg;

  localparam int DW   = 8;
  localparam int PW   = 2 * (DW + 1);
  localparam int ITER = DW + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef logic signed [DW:0]   sw_in_t;
  typedef logic        [DW:0]   mag_t;
  typedef logic signed [PW-1:0] product_t;

  typedef struct packed {
    sw_in_t multiplicand;
    sw_in_t multiplier;
  } registers_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  // Unsigned magnitude; the most negative operand maps to 2**DW, which still fits.
  function automatic mag_t magnitude(input sw_in_t v);
    magnitude = v[DW] ? mag_t'(-v) : mag_t'(v);
  endfunction

endpackage

// File: rtl/shift_add_unit.sv
// Iterative unsigned shift-add datapath: one partial product per step,
// flags the final iteration to the controlling FSM.
module shift_add_unit
  import switch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init,
  input  logic          i_step,
  input  logic [DW:0]   i_md_mag,
  input  logic [DW:0]   i_mr_mag,
  output logic [PW-1:0] o_acc,
  output logic          o_last
);

  logic [DW:0]   r_md_mag;
  logic [DW:0]   r_mr_mag;
  logic [PW-1:0] r_acc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_partial;

  assign w_partial = {{(PW-DW-1){1'b0}}, r_md_mag} << r_count;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md_mag <= '0;
      r_mr_mag <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_init) begin
      r_md_mag <= i_md_mag;
      r_mr_mag <= i_mr_mag;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      if (r_mr_mag[0]) r_acc <= r_acc + w_partial;
      r_mr_mag <= r_mr_mag >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_count == CW'(ITER - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the signed switch multiplier: operand capture,
// IDLE/RUN/DONE control of the shift-add unit, sign fix and product hold.
module mult_seq_ctrl
  import switch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW:0]          sw_i,
  input  logic                 sel_i,
  input  logic                 load_i,
  input  logic                 start_i,
  output logic signed [PW-1:0] product_o,
  output logic                 busy_o,
  output logic                 done_o
);

  mult_state_t   r_state;
  mult_state_t   w_next;
  registers_t    r_regs;
  logic          r_sign;
  logic [PW-1:0] r_product;

  logic          w_init;
  logic          w_step;
  logic [DW:0]   w_md_mag;
  logic [DW:0]   w_mr_mag;
  logic [PW-1:0] w_acc;
  logic          w_last;
  logic [PW-1:0] w_result;

  assign w_md_mag = magnitude(r_regs.multiplicand);
  assign w_mr_mag = magnitude(r_regs.multiplier);

  shift_add_unit u_shift_add (
    .clk      (clk),
    .rst      (rst),
    .i_init   (w_init),
    .i_step   (w_step),
    .i_md_mag (w_md_mag),
    .i_mr_mag (w_mr_mag),
    .o_acc    (w_acc),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: defaults come first so no path through the case leaves a signal unassigned.
  always_comb begin
    w_next = r_state;
    w_init = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_init = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A start sharing a cycle with a load sees the old operands; the load still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs    <= '0;
      r_sign    <= 1'b0;
      r_product <= '0;
    end else begin
      if (r_state == IDLE && load_i) begin
        if (sel_i) r_regs.multiplier   <= sw_i;
        else       r_regs.multiplicand <= sw_i;
      end
      if (w_init)           r_sign    <= r_regs.multiplicand[DW] ^ r_regs.multiplier[DW];
      if (r_state == DONE)  r_product <= w_result;
    end
  end

  assign w_result = r_sign ? -w_acc : w_acc;

  // The new product is visible during the DONE cycle so it lines up with done_o.
  assign busy_o    = (r_state == RUN);
  assign done_o    = (r_state == DONE);
  assign product_o = done_o ? w_result : r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: scoreboard of expected products,
// timing of busy/done, dropped pulses during a multiply, and mid-run reset.
module tb_mult_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [8:0]  sw_i;
  logic               sel_i;
  logic               load_i;
  logic               start_i;
  logic signed [17:0] product_o;
  logic               busy_o;
  logic               done_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sw_i      (sw_i),
    .sel_i     (sel_i),
    .load_i    (load_i),
    .start_i   (start_i),
    .product_o (product_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (rst && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("product", product_o, e);
      end
    end
  end

  // Callers enter and leave every task just after a rising edge.
  task automatic load(input bit sel, input int v);
    sw_i   = 9'(v);
    sel_i  = sel;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
  endtask

  // inj_cycle > 0 pulses start_i (and load_i of 99 when inj_load) in that cycle after start.
  task automatic mult(input int md, input int mr, input int inj_cycle,
                      input bit inj_load, input bit do_load);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    if (do_load) begin
      load(1'b0, md);
      load(1'b1, mr);
    end
    exp_q.push_back(md * mr);
    start_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start_i = (k == inj_cycle);
      load_i  = inj_load && (k == inj_cycle);
      sel_i   = 1'b0;
      sw_i    = 9'sd99;
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o && done_at == 0) done_at = k;
      if (done_at != 0 && k == done_at + 1) begin
        check("done_pulse_width", int'(done_o), 0);
        break;
      end
    end
    if (done_at == 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end else begin
      check("latency", done_at, 10);
      check("busy_cycles", busy_cnt, 9);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int b;
    sw_i = '0; sel_i = 1'b0; load_i = 1'b0; start_i = 1'b0;

    #12;
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_product", product_o, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    mult(5, 3, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("product_hold", product_o, 15);

    mult(-7, 12, 0, 1'b0, 1'b1);
    check("product_raw_hex", int'(product_o[17:0]), 'h3FFAC);
    mult(-256, -256, 0, 1'b0, 1'b1);
    mult(-256, 255, 0, 1'b0, 1'b1);
    mult(0, 255, 0, 1'b0, 1'b1);

    // Pulses during RUN are dropped; a restart without loads must reuse 20 and 11.
    mult(20, 11, 3, 1'b1, 1'b1);
    mult(20, 11, 0, 1'b0, 1'b0);

    // start_i during DONE must not launch another multiply.
    mult(-9, 7, 10, 1'b0, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("queue_empty_after_done_start", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 511)) - 256;
      b = int'($urandom_range(0, 511)) - 256;
      mult(a, b, 0, 1'b0, 1'b1);
    end

    mult(-3, 50, 0, 1'b0, 1'b1);
    load(1'b0, 5);
    load(1'b1, 3);
    start_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    check("busy_before_rst", int'(busy_o), 1);
    rst = 1'b0;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_product", product_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("product_after_rst", product_o, 0);

    mult(-3, -100, 0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
